ifft_4_stream: RTL and testbench
================================

Name: ifft_4_stream

Overview:
- Streaming 4-point inverse DFT: the inverse-direction counterpart of the team's fft_2 butterfly.
- Accepts one frame of 4 complex frequency-domain samples serially over a valid/ready interface and computes the time-domain frame with two radix-2 inverse butterfly stages.
- Multiplier-free: the ±j twiddles are implemented as swap/negate.
- Emits the 4 results serially over a valid/ready interface, with optional 1/4 scaling so that an FFT→IFFT round trip is unity gain.

Parameters:
- DATA_WIDTH, 64, width of each real/imag component; signed two's complement.
- SCALE, 1, 1 = arithmetic shift right by 2 (divide by N=4, floor); 0 = no scaling, wrap modulo 2^DATA_WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts a sample this cycle
- in_r  in  DATA_WIDTH  input real, X[k]
- in_i  in  DATA_WIDTH  input imag, X[k]
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- out_r  out  DATA_WIDTH  output real, x[n]
- out_i  out  DATA_WIDTH  output imag, x[n]
- out_idx  out  2  index n of the current output
- out_last  out  1  high with out_valid when out_idx==3
- busy  out  1  high in any state other than LOAD with count 0

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values: state=LOAD, load count=0, out index=0, in_ready=1, out_valid=0, out_last=0, busy=0, out_r=out_i=0, out_idx=0. All sample registers are cleared.
- Reset mid-operation: any partial frame or pending output is discarded. The first transfer after reset is treated as X[0].
- FSM states: LOAD, STAGE1, STAGE2, UNLOAD.
- LOAD:
  - in_ready=1.
  - A transfer occurs when in_valid & in_ready; the sample is stored in X[count] and count increments.
  - Samples arrive in natural order k=0..3.
  - On the transfer with count==3, go to STAGE1.
  - Gaps (in_valid low) are allowed; they hold state.
- STAGE1 (1 cycle, in_ready=0), on DATA_WIDTH+2-bit sign-extended values:
  - a=X0+X2, b=X0−X2, c=X1+X3, d=X1−X3 (complex).
  - Go to STAGE2.
- STAGE2 (1 cycle, in_ready=0):
  - y0=a+c, y2=a−c.
  - y1 = (b_r−d_i, b_i+d_r), i.e. b+jd.
  - y3 = (b_r+d_i, b_i−d_r), i.e. b−jd.
  - Go to UNLOAD.
- Scaling:
  - SCALE=1: each component is arithmetic-shifted right by 2 (floor toward −inf), then truncated to the DATA_WIDTH LSBs.
  - SCALE=0: take the DATA_WIDTH LSBs directly (wrap).
- UNLOAD:
  - out_valid=1; out_r/out_i/out_idx present y[n] for n=0..3 in natural order.
  - Advance n when out_valid & out_ready.
  - While out_ready=0, outputs are held stable (no change to data, idx or last).
  - On the transfer with n==3: go to LOAD, count=0, out_valid=0 next cycle.
- Latency: out_valid rises exactly 2 cycles after the clock edge accepting X[3]. Outputs are registered.
- No frame overlap:
  - in_ready=0 in STAGE1/STAGE2/UNLOAD.
  - Minimum frame period is 10 cycles with continuous valid/ready.
- in_valid asserted while in_ready=0 is ignored; the source must hold data.
- Simultaneous final output transfer and in_valid in the same cycle: the input is not accepted that cycle. in_ready rises the following cycle.

Test Plan:
- Frequency basis X1: SCALE=1, X=[0, 4, 0, 0] (imag 0) → outputs (1,0), (0,1), (−1,0), (0,−1); out_idx 0..3; out_last only on idx 3.
- Round trip with the fft of [1,2,3,4]: SCALE=1, X=[10, −2+2j, −2, −2−2j] → outputs (1,0), (2,0), (3,0), (4,0); out_valid rises 2 cycles after X3 is accepted.
- Floor scaling: SCALE=1, X=[−1, 0, 0, 0] → all four outputs (−1,0). With SCALE=0 the same input gives all (−1,0); X=[4,0,0,0] gives all (4,0).
- Backpressure: during UNLOAD, hold out_ready=0 for 3 cycles at idx 1 → out_r/out_i/out_idx stay constant; in_ready stays 0; the frame then completes normally.
- Input gaps plus back-to-back frames: insert in_valid=0 bubbles between X1 and X2, then send a second frame immediately after the first out_last → both frames are correct; no sample of frame 2 is accepted before in_ready reasserts.
- Async reset mid-load: accept 2 samples, pulse rst_n low between clock edges → in_ready=1, out_valid=0 immediately. A full new 4-sample frame then yields correct results, unaffected by the discarded samples.

Source files
------------

// File: rtl/ifft_4_stream.sv
// ifft_4_stream: streaming 4-point inverse DFT with two radix-2 butterfly stages.
// Revision 1.0 - initial release.
`default_nettype none

module ifft_4_stream #(
   parameter int DATA_WIDTH = 64,
   parameter int SCALE      = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_r,
   input  logic [DATA_WIDTH-1:0] in_i,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_r,
   output logic [DATA_WIDTH-1:0] out_i,
   output logic [1:0]            out_idx,
   output logic                  out_last,
   output logic                  busy
);

   localparam int EW = DATA_WIDTH + 2;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      STAGE1 = 2'd1,
      STAGE2 = 2'd2,
      UNLOAD = 2'd3
   } state_t;

   state_t                      state_q, state_d;
   logic [1:0]                  count_q, count_d;
   logic [3:0][DATA_WIDTH-1:0]  xr_q, xr_d, xi_q, xi_d;
   logic [3:0][DATA_WIDTH-1:0]  yr_q, yr_d, yi_q, yi_d;
   logic signed [EW-1:0]        ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
   logic signed [EW-1:0]        cr_q, cr_d, ci_q, ci_d, dr_q, dr_d, di_q, di_d;
   logic                        out_valid_q, out_valid_d;
   logic                        out_last_q, out_last_d;
   logic [1:0]                  out_idx_q, out_idx_d;
   logic [DATA_WIDTH-1:0]       out_r_q, out_r_d, out_i_q, out_i_d;
   logic [1:0]                  idx_next;
   logic [3:0][DATA_WIDTH-1:0]  y_r_w, y_i_w;

   function automatic logic signed [EW-1:0] sext(input logic [DATA_WIDTH-1:0] v);
      return {{2{v[DATA_WIDTH-1]}}, v};
   endfunction

   // Arithmetic shift floors toward -inf; the cast keeps only the low DATA_WIDTH bits.
   function automatic logic [DATA_WIDTH-1:0] scale(input logic signed [EW-1:0] v);
      logic signed [EW-1:0] s;
      s = (SCALE != 0) ? (v >>> 2) : v;
      return DATA_WIDTH'(s);
   endfunction

   // Second butterfly: +j/-j twiddles on d become swap/negate.
   always_comb begin
      y_r_w[0] = scale(ar_q + cr_q);
      y_i_w[0] = scale(ai_q + ci_q);
      y_r_w[1] = scale(br_q - di_q);
      y_i_w[1] = scale(bi_q + dr_q);
      y_r_w[2] = scale(ar_q - cr_q);
      y_i_w[2] = scale(ai_q - ci_q);
      y_r_w[3] = scale(br_q + di_q);
      y_i_w[3] = scale(bi_q - dr_q);
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      xr_d        = xr_q;
      xi_d        = xi_q;
      yr_d        = yr_q;
      yi_d        = yi_q;
      ar_d        = ar_q;
      ai_d        = ai_q;
      br_d        = br_q;
      bi_d        = bi_q;
      cr_d        = cr_q;
      ci_d        = ci_q;
      dr_d        = dr_q;
      di_d        = di_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_idx_d   = out_idx_q;
      out_r_d     = out_r_q;
      out_i_d     = out_i_q;
      idx_next    = out_idx_q + 2'd1;

      unique case (state_q)
         LOAD: begin
            if (in_valid) begin
               xr_d[count_q] = in_r;
               xi_d[count_q] = in_i;
               count_d       = count_q + 2'd1;
               if (count_q == 2'd3) state_d = STAGE1;
            end
         end
         STAGE1: begin
            ar_d    = sext(xr_q[0]) + sext(xr_q[2]);
            ai_d    = sext(xi_q[0]) + sext(xi_q[2]);
            br_d    = sext(xr_q[0]) - sext(xr_q[2]);
            bi_d    = sext(xi_q[0]) - sext(xi_q[2]);
            cr_d    = sext(xr_q[1]) + sext(xr_q[3]);
            ci_d    = sext(xi_q[1]) + sext(xi_q[3]);
            dr_d    = sext(xr_q[1]) - sext(xr_q[3]);
            di_d    = sext(xi_q[1]) - sext(xi_q[3]);
            state_d = STAGE2;
         end
         STAGE2: begin
            yr_d        = y_r_w;
            yi_d        = y_i_w;
            out_r_d     = y_r_w[0];
            out_i_d     = y_i_w[0];
            out_idx_d   = 2'd0;
            out_last_d  = 1'b0;
            out_valid_d = 1'b1;
            state_d     = UNLOAD;
         end
         UNLOAD: begin
            if (out_ready) begin
               if (out_idx_q == 2'd3) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  out_idx_d   = 2'd0;
                  count_d     = 2'd0;
                  state_d     = LOAD;
               end else begin
                  out_idx_d  = idx_next;
                  out_r_d    = yr_q[idx_next];
                  out_i_d    = yi_q[idx_next];
                  out_last_d = (idx_next == 2'd3);
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         count_q     <= 2'd0;
         xr_q        <= '0;
         xi_q        <= '0;
         yr_q        <= '0;
         yi_q        <= '0;
         ar_q        <= '0;
         ai_q        <= '0;
         br_q        <= '0;
         bi_q        <= '0;
         cr_q        <= '0;
         ci_q        <= '0;
         dr_q        <= '0;
         di_q        <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_idx_q   <= 2'd0;
         out_r_q     <= '0;
         out_i_q     <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         xr_q        <= xr_d;
         xi_q        <= xi_d;
         yr_q        <= yr_d;
         yi_q        <= yi_d;
         ar_q        <= ar_d;
         ai_q        <= ai_d;
         br_q        <= br_d;
         bi_q        <= bi_d;
         cr_q        <= cr_d;
         ci_q        <= ci_d;
         dr_q        <= dr_d;
         di_q        <= di_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_idx_q   <= out_idx_d;
         out_r_q     <= out_r_d;
         out_i_q     <= out_i_d;
      end
   end

   assign in_ready  = (state_q == LOAD);
   assign busy      = !((state_q == LOAD) && (count_q == 2'd0));
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_idx   = out_idx_q;
   assign out_r     = out_r_q;
   assign out_i     = out_i_q;

endmodule

`default_nettype wire

// File: tb/tb_ifft_4_stream.sv
// tb_ifft_4_stream: directed bench for ifft_4_stream (SCALE=1 instance a, SCALE=0 instance b).
`default_nettype none

module tb_ifft_4_stream;

   logic        clk, rst_n, in_valid, out_ready, bsel;
   logic [63:0] in_r, in_i;
   logic        in_valid_a, in_valid_b, out_ready_a, out_ready_b;
   logic        in_ready_a, out_valid_a, out_last_a, busy_a;
   logic        in_ready_b, out_valid_b, out_last_b, busy_b;
   logic [63:0] out_r_a, out_i_a, out_r_b, out_i_b;
   logic [1:0]  out_idx_a, out_idx_b;
   logic        m_in_ready, m_out_valid, m_out_last, m_busy;
   logic [63:0] m_out_r, m_out_i;
   logic [1:0]  m_out_idx;

   int          total = 0;
   int          bad   = 0;
   longint      xr[4], xi[4], er[4], ei[4];

   assign in_valid_a  = in_valid & ~bsel;
   assign in_valid_b  = in_valid & bsel;
   assign out_ready_a = out_ready & ~bsel;
   assign out_ready_b = out_ready & bsel;
   assign m_in_ready  = bsel ? in_ready_b  : in_ready_a;
   assign m_out_valid = bsel ? out_valid_b : out_valid_a;
   assign m_out_last  = bsel ? out_last_b  : out_last_a;
   assign m_busy      = bsel ? busy_b      : busy_a;
   assign m_out_r     = bsel ? out_r_b     : out_r_a;
   assign m_out_i     = bsel ? out_i_b     : out_i_a;
   assign m_out_idx   = bsel ? out_idx_b   : out_idx_a;

   ifft_4_stream #(.DATA_WIDTH(64), .SCALE(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_r(in_r), .in_i(in_i), .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_r(out_r_a), .out_i(out_i_a), .out_idx(out_idx_a), .out_last(out_last_a),
      .busy(busy_a)
   );

   ifft_4_stream #(.DATA_WIDTH(64), .SCALE(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_r(in_r), .in_i(in_i), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_r(out_r_b), .out_i(out_i_b), .out_idx(out_idx_b), .out_last(out_last_b),
      .busy(busy_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input longint r, input longint i);
      int n = 0;
      in_valid = 1'b1;
      in_r     = r;
      in_i     = i;
      while (!m_in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("in_ready_wait", {63'd0, m_in_ready}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_frame();
      for (int k = 0; k < 4; k++) send(xr[k], xi[k]);
   endtask

   // pre_load drives frame X[0] from xr/xi during the final output transfer.
   task automatic expect_out(input int k, input bit pre_load);
      int n = 0;
      out_ready = 1'b1;
      while (!m_out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("out_valid", {63'd0, m_out_valid}, 64'd1);
      check("out_idx", {62'd0, m_out_idx}, 64'(k));
      check("out_r", m_out_r, er[k]);
      check("out_i", m_out_i, ei[k]);
      check("out_last", {63'd0, m_out_last}, (k == 3) ? 64'd1 : 64'd0);
      if (pre_load) begin
         in_valid = 1'b1;
         in_r     = xr[0];
         in_i     = xi[0];
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_frame();
      for (int k = 0; k < 4; k++) expect_out(k, 1'b0);
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; bsel = 1'b0;
      in_r = '0; in_i = '0;
      #1;
      check("rst_in_ready", {63'd0, in_ready_a}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
      check("rst_out_last", {63'd0, out_last_a}, 64'd0);
      check("rst_busy", {63'd0, busy_a}, 64'd0);
      check("rst_out_r", out_r_a, 64'd0);
      check("rst_out_i", out_i_a, 64'd0);
      check("rst_out_idx", {62'd0, out_idx_a}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Frequency basis X1
      xr = '{0, 4, 0, 0};  xi = '{0, 0, 0, 0};
      er = '{1, 0, -1, 0}; ei = '{0, 1, 0, -1};
      send_frame();
      expect_frame();

      // Round trip of fft([1,2,3,4]) with latency check
      xr = '{10, -2, -2, -2}; xi = '{0, 2, 0, -2};
      er = '{1, 2, 3, 4};     ei = '{0, 0, 0, 0};
      send_frame();
      check("lat_valid_e0", {63'd0, m_out_valid}, 64'd0);
      check("lat_in_ready", {63'd0, m_in_ready}, 64'd0);
      check("lat_busy", {63'd0, m_busy}, 64'd1);
      @(negedge clk);
      check("lat_valid_e1", {63'd0, m_out_valid}, 64'd0);
      @(negedge clk);
      check("lat_valid_e2", {63'd0, m_out_valid}, 64'd1);
      expect_frame();

      // Floor scaling plus backpressure at idx 1
      xr = '{-1, 0, 0, 0};    xi = '{0, 0, 0, 0};
      er = '{-1, -1, -1, -1}; ei = '{0, 0, 0, 0};
      send_frame();
      expect_out(0, 1'b0);
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("bp_idx", {62'd0, m_out_idx}, 64'd1);
         check("bp_r", m_out_r, er[1]);
         check("bp_valid", {63'd0, m_out_valid}, 64'd1);
         check("bp_in_ready", {63'd0, m_in_ready}, 64'd0);
         @(negedge clk);
      end
      for (int k = 1; k < 4; k++) expect_out(k, 1'b0);

      // Input gaps, then back-to-back frame offered during final output
      xr = '{0, 4, 0, 0};  xi = '{0, 0, 0, 0};
      er = '{1, 0, -1, 0}; ei = '{0, 1, 0, -1};
      send(xr[0], xi[0]);
      send(xr[1], xi[1]);
      repeat (3) @(negedge clk);
      check("gap_busy", {63'd0, m_busy}, 64'd1);
      check("gap_in_ready", {63'd0, m_in_ready}, 64'd1);
      send(xr[2], xi[2]);
      send(xr[3], xi[3]);
      for (int k = 0; k < 3; k++) expect_out(k, 1'b0);
      xr = '{10, -2, -2, -2}; xi = '{0, 2, 0, -2};
      expect_out(3, 1'b1);
      check("b2b_in_ready", {63'd0, m_in_ready}, 64'd1);
      check("b2b_busy", {63'd0, m_busy}, 64'd0);
      check("b2b_out_valid", {63'd0, m_out_valid}, 64'd0);
      er = '{1, 2, 3, 4}; ei = '{0, 0, 0, 0};
      send_frame();
      expect_frame();

      // Async reset mid-load discards the partial frame
      send(7, 7);
      send(-5, 3);
      #2 rst_n = 1'b0;
      #1;
      check("arst_in_ready", {63'd0, m_in_ready}, 64'd1);
      check("arst_out_valid", {63'd0, m_out_valid}, 64'd0);
      check("arst_busy", {63'd0, m_busy}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame();
      expect_frame();

      // SCALE=0 instance: no scaling, wrap
      bsel = 1'b1;
      xr = '{-1, 0, 0, 0};    xi = '{0, 0, 0, 0};
      er = '{-1, -1, -1, -1}; ei = '{0, 0, 0, 0};
      send_frame();
      expect_frame();
      xr = '{4, 0, 0, 0};
      er = '{4, 4, 4, 4};
      send_frame();
      expect_frame();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
